// File: rtl/instr_mem_loader_if.sv
// Host byte-stream handshake plus instruction-RAM write port of the program loader.
// slave = loader side, master = host / RAM side.
interface instr_mem_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;

    modport slave (
        input  in_valid, in_data,
        output in_ready, we, wa, wd
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, we, wa, wd
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: header byte N (0 = 256), then 4*N bytes packed MSB first into
// 32-bit RAM writes while the CPU is held. INSTR_LOADER_CHECKSUM_EN adds a trailing sum byte.
module instr_mem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    instr_mem_loader_if.slave bus,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

`ifdef INSTR_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_WRITE, S_CHK, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_WRITE, S_DONE} state_t;
`endif

    state_t            r_state;
    state_t            w_state_nx;
    logic [ADDR_W-1:0] r_word_cnt;
    logic [ADDR_W-1:0] r_n;
    logic [ADDR_W-1:0] r_wa;
    logic [1:0]        r_byte_cnt;
    logic [DATA_W-9:0] r_shreg;
    logic [DATA_W-1:0] r_wd;
    logic              w_in_ready;
    logic              w_we;
    logic              w_xfer;
    logic              w_start_ok;
    logic              w_last;
    logic              w_word_full;
    logic [DATA_W-1:0] w_word;

    assign w_xfer      = bus.in_valid & w_in_ready;
    assign w_start_ok  = start & ((r_state == S_IDLE) | (r_state == S_DONE));
    // N-1 in ADDR_W bits turns N=0 into a 256-word load ending at counter 0xFF
    assign w_last      = (r_word_cnt == (r_n - ADDR_W'(1)));
    assign w_word_full = (r_byte_cnt == 2'd3);
    assign w_word      = {r_shreg, bus.in_data};

    assign bus.in_ready = w_in_ready;
    assign bus.we       = w_we;
    assign bus.wa       = r_wa;
    assign bus.wd       = r_wd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nx = S_HDR;
            S_HDR:   if (w_xfer) w_state_nx = S_DATA;
            S_DATA:  if (w_xfer && w_word_full) w_state_nx = S_WRITE;
            S_WRITE: begin
                if (w_last) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    w_state_nx = S_CHK;
`else
                    w_state_nx = S_DONE;
`endif
                end else begin
                    w_state_nx = S_DATA;
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CHK:   if (w_xfer) w_state_nx = S_DONE;
`endif
            S_DONE:  if (start) w_state_nx = S_HDR;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        w_we       = 1'b0;
        cpu_hold   = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_HDR, S_DATA: begin
                w_in_ready = 1'b1;
                cpu_hold   = 1'b1;
            end
            S_WRITE: begin
                w_we     = 1'b1;
                cpu_hold = 1'b1;
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CHK: begin
                w_in_ready = 1'b1;
                cpu_hold   = 1'b1;
            end
`endif
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic       r_err;
    logic [7:0] r_sum;

    assign err = r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
            r_sum <= '0;
        end else begin
            if (w_start_ok) begin
                r_err <= 1'b0;
                r_sum <= '0;
            end else if (w_xfer && (r_state == S_DATA)) begin
                r_sum <= r_sum + bus.in_data;
            end else if (w_xfer && (r_state == S_CHK)) begin
                r_err <= (bus.in_data != r_sum);
            end
        end
    end
`else
    assign err = 1'b0;
`endif

    // wa/wd are loaded with the 4th byte so they are already valid during the WRITE cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
            r_n        <= '0;
            r_shreg    <= '0;
            r_wa       <= '0;
            r_wd       <= '0;
        end else begin
            if (w_start_ok) begin
                r_word_cnt <= '0;
                r_byte_cnt <= '0;
            end
            case (r_state)
                S_HDR: begin
                    if (w_xfer) r_n <= ADDR_W'(bus.in_data);
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_shreg    <= w_word[DATA_W-9:0];
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (w_word_full) begin
                            r_wa <= r_word_cnt;
                            r_wd <= w_word;
                        end
                    end
                end
                S_WRITE: r_word_cnt <= r_word_cnt + ADDR_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: a frame model queues expected RAM writes,
// a negedge monitor pops and compares them whenever the loader strobes we.
module tb_instr_mem_loader;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic cpu_hold;
    logic done;
    logic err;

    instr_mem_loader_if #(.ADDR_W(8), .DATA_W(32)) ifc ();

    instr_mem_loader #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .bus      (ifc),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (ifc.we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: actual wa=%0h wd=%0h required no write", ifc.wa, ifc.wd);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write_wa", {24'h0, ifc.wa}, {24'h0, mon_e.a});
                chk("write_wd", ifc.wd, mon_e.d);
            end
            chk("in_ready_in_write", {31'h0, ifc.in_ready}, 32'h0);
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, {31'h0, ifc.in_ready}, 32'h0);
        chk({tag, "_we"}, {31'h0, ifc.we}, 32'h0);
        chk({tag, "_wa"}, {24'h0, ifc.wa}, 32'h0);
        chk({tag, "_wd"}, ifc.wd, 32'h0);
        chk({tag, "_cpu_hold"}, {31'h0, cpu_hold}, 32'h0);
        chk({tag, "_done"}, {31'h0, done}, 32'h0);
        chk({tag, "_err"}, {31'h0, err}, 32'h0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        ifc.in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte; transfer happens on the posedge following return
    task automatic send_byte(input logic [7:0] b, input int gap);
        int tmo;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            ifc.in_valid = 1'b0;
        end
        @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.in_data  = b;
        tmo = 0;
        while (ifc.in_ready !== 1'b1 && tmo < 50) begin
            @(negedge clk);
            tmo++;
        end
        if (tmo >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: actual in_ready=%b required 1 within 50 cycles", ifc.in_ready);
        end
    endtask

    // Reference frame: word i goes to address i; checksum is the byte sum mod 256.
    // start_at/abort_at index data bytes (-1 = unused).
    task automatic load_frame(input logic [7:0] n, input logic [31:0] w[$], input int gmax,
                              input logic [7:0] cdelta, input int start_at, input int abort_at);
        logic [7:0] sum;
        logic [7:0] b;
        logic       exp_err;
        int         n_exp;
        int         tmo;
        wr_t        e;
        sum = 8'h00;
        n_exp = (abort_at >= 0) ? (abort_at + 1) / 4 : w.size();
        pulse_start();
        chk("hdr_in_ready", {31'h0, ifc.in_ready}, 32'h1);
        chk("hdr_cpu_hold", {31'h0, cpu_hold}, 32'h1);
        chk("start_clears_done", {31'h0, done}, 32'h0);
        for (int i = 0; i < n_exp; i++) begin
            e.a = 8'(i);
            e.d = w[i];
            exp_q.push_back(e);
        end
        send_byte(n, $urandom_range(gmax, 0));
        for (int i = 0; i < w.size(); i++) begin
            for (int k = 0; k < 4; k++) begin
                b = w[i][31 - 8 * k -: 8];
                sum = sum + b;
                send_byte(b, $urandom_range(gmax, 0));
                if (4 * i + k == start_at) begin
                    pulse_start();
                    chk("start_ignored_hold", {31'h0, cpu_hold}, 32'h1);
                end
                if (4 * i + k == abort_at) begin
                    @(negedge clk);
                    ifc.in_valid = 1'b0;
                    reset_n = 1'b0;
                    #1;
                    check_all_zero("abort");
                    @(negedge clk);
                    reset_n = 1'b1;
                    chk("abort_writes_drained", exp_q.size(), 32'h0);
                    return;
                end
            end
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(sum + cdelta, $urandom_range(gmax, 0));
        exp_err = (cdelta != 8'h00);
`else
        exp_err = 1'b0;
`endif
        @(negedge clk);
        ifc.in_valid = 1'b0;
        tmo = 0;
        while (done !== 1'b1 && tmo < 200) begin
            @(negedge clk);
            tmo++;
        end
        chk("done_set", {31'h0, done}, 32'h1);
        chk("done_cpu_hold", {31'h0, cpu_hold}, 32'h0);
        chk("done_in_ready", {31'h0, ifc.in_ready}, 32'h0);
        chk("done_err", {31'h0, err}, {31'h0, exp_err});
        chk("writes_drained", exp_q.size(), 32'h0);
        repeat (3) @(negedge clk);
        chk("no_extra_write_done", {31'h0, done}, 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual still running required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] frame1[$];
        logic [31:0] big[$];
        logic [31:0] rnd[$];
        int          n;
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        frame1 = '{32'h20010003, 32'h20020009};
        load_frame(8'd2, frame1, 0, 8'h00, -1, -1);
        load_frame(8'd2, frame1, 3, 8'h00, -1, -1);

        for (int i = 0; i < 256; i++) big.push_back(32'(i));
        load_frame(8'd0, big, 0, 8'h00, -1, -1);

        for (int i = 0; i < 4; i++) rnd.push_back($urandom);
        load_frame(8'd4, rnd, 1, 8'h00, 8, -1);

        load_frame(8'd2, frame1, 0, 8'h00, -1, 5);
        load_frame(8'd2, frame1, 2, 8'h00, -1, -1);

`ifdef INSTR_LOADER_CHECKSUM_EN
        load_frame(8'd2, frame1, 0, 8'h01, -1, -1);
`endif

        for (int r = 0; r < 4; r++) begin
            rnd.delete();
            n = $urandom_range(6, 1);
            for (int i = 0; i < n; i++) rnd.push_back($urandom);
            load_frame(8'(n), rnd, 3, 8'(r[0]), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
